// File: rtl/gbar_sync_unit_pkg.sv
// Shared types and width helpers for the global-barrier sync unit.
package gbar_sync_unit_pkg;

    function automatic int gbar_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 8;
    localparam int GBAR_NC_WIDTH     = gbar_width(GBAR_NUM_CORES);
    localparam int GBAR_NB_WIDTH     = gbar_width(GBAR_NUM_BARRIERS);

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
        logic [GBAR_NC_WIDTH-1:0] core_id;
    } gbar_req_t;

    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/gbar_rr_arbiter.sv
// N-input round-robin arbiter: one-hot grant plus index, priority pointer
// advances past the last granted requester.
module gbar_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] ptr;
    logic [W-1:0] k;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = '0;
        for (int i = 0; i < N; i++) begin
            k = W'((int'(ptr) + i) % N);
            if (!grant_valid && req[k]) begin
                grant_valid = 1'b1;
                grant[k]    = 1'b1;
                grant_idx   = k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gbar_sync_unit.sv
// Cluster-level global-barrier responder: counts per-barrier arrivals and
// broadcasts a one-cycle release when the last participant arrives.
module gbar_sync_unit
    import gbar_sync_unit_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NC_WIDTH     = gbar_width(NUM_CORES),
    parameter int NB_WIDTH     = gbar_width(NUM_BARRIERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_core_id,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          busy,
    output logic                          err
);

    localparam logic [NC_WIDTH:0] ONE = 1;

    logic [NB_WIDTH-1:0]  id_a   [NUM_CORES];
    logic [NC_WIDTH-1:0]  size_a [NUM_CORES];
    logic [NC_WIDTH-1:0]  cid_a  [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign id_a[g]   = req_id[g*NB_WIDTH +: NB_WIDTH];
        assign size_a[g] = req_size_m1[g*NC_WIDTH +: NC_WIDTH];
        assign cid_a[g]  = req_core_id[g*NC_WIDTH +: NC_WIDTH];
    end

    logic [NC_WIDTH-1:0] gidx;
    logic                gvalid;

    gbar_rr_arbiter #(
        .N (NUM_CORES),
        .W (NC_WIDTH)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .grant       (req_ready),
        .grant_idx   (gidx),
        .grant_valid (gvalid)
    );

    logic [NUM_CORES-1:0] mask  [NUM_BARRIERS];
    logic [NC_WIDTH:0]    count [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]  size  [NUM_BARRIERS];

    logic [NB_WIDTH-1:0]  sel_id;
    logic [NC_WIDTH-1:0]  sel_size;
    logic [NC_WIDTH-1:0]  eff_size;
    logic [NC_WIDTH:0]    new_count;
    logic                 first, dup, complete, size_err, cid_err, any_count;

    always_comb begin
        sel_id    = id_a[gidx];
        sel_size  = size_a[gidx];
        first     = (count[sel_id] == '0);
        dup       = mask[sel_id][gidx];
        // The first arrival defines the barrier size; later ones must agree.
        eff_size  = first ? sel_size : size[sel_id];
        new_count = count[sel_id] + ONE;
        complete  = gvalid && !dup && (new_count == ({1'b0, eff_size} + ONE));
        size_err  = !first && (sel_size != size[sel_id]);
        cid_err   = (cid_a[gidx] != gidx);
        any_count = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            any_count = any_count | (count[b] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask[b]  <= '0;
                count[b] <= '0;
                size[b]  <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= complete;
            busy      <= any_count;
            if (complete) begin
                rsp_id <= sel_id;
            end
            if (gvalid && (dup || size_err || cid_err)) begin
                err <= 1'b1;
            end
            // Completing fire clears the entry so the next cycle starts a new epoch.
            if (gvalid && !dup) begin
                if (complete) begin
                    mask[sel_id]  <= '0;
                    count[sel_id] <= '0;
                    size[sel_id]  <= '0;
                end else begin
                    mask[sel_id][gidx] <= 1'b1;
                    count[sel_id]      <= new_count;
                    if (first) begin
                        size[sel_id] <= sel_size;
                    end
                end
            end
        end
    end

endmodule
